// File: rtl/timer_pkg.sv
// Shared encodings and defaults for the multi-channel millisecond delay timer.
package timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int DEFAULT_TICKS_PER_MS = 100000;

endpackage

// File: rtl/delay_channel.sv
// One delay channel: prescaler divides the clock down to ms ticks, the ms counter
// counts the latched duration, and done pulses on the edge after both reach zero.
module delay_channel
  import timer_pkg::*;
#(
  parameter int DUR_W        = 11,
  parameter int TICKS_PER_MS = DEFAULT_TICKS_PER_MS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic             periodic,
  input  logic [DUR_W-1:0] duration,
  output logic             done,
  output logic             busy,
  output logic [DUR_W-1:0] remaining_ms
);

  localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(TICKS_PER_MS - 1);

  ch_state_e        state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DUR_W-1:0] ms_q, ms_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             mode_q, mode_d;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dur_d   = dur_q;
    mode_d  = mode_q;
    if (start) begin
      // A zero duration expires on the very next edge and never reloads.
      state_d = ST_RUN;
      dur_d   = duration;
      mode_d  = (periodic && (duration != '0)) ? MODE_PERIODIC : MODE_ONESHOT;
      pre_d   = (duration == '0) ? '0 : PRE_RELOAD;
      ms_d    = (duration == '0) ? '0 : duration - 1'b1;
      rem_d   = duration;
    end else if (state_q == ST_RUN) begin
      if (cancel) begin
        state_d = ST_IDLE;
        pre_d   = '0;
        ms_d    = '0;
        rem_d   = '0;
      end else if ((pre_q == '0) && (ms_q == '0)) begin
        done_d = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          pre_d = PRE_RELOAD;
          ms_d  = dur_q - 1'b1;
          rem_d = dur_q;
        end else begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end
      end else if (pre_q == '0) begin
        // Old ms count equals the new count plus one, i.e. the new whole-ms remainder.
        pre_d = PRE_RELOAD;
        ms_d  = ms_q - 1'b1;
        rem_d = ms_q;
      end else begin
        pre_d = pre_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      ms_q    <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    dur_q  <= dur_d;
    mode_q <= mode_d;
  end

  assign done         = done_q;
  assign busy         = (state_q == ST_RUN);
  assign remaining_ms = rem_q;

endmodule

// File: rtl/multi_delay_timer.sv
// NUM_CH independent millisecond delay timers sharing one clock and reset;
// per-channel buses are packed with channel i at [i*DUR_W +: DUR_W].
module multi_delay_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DUR_W        = 11,
  parameter int TICKS_PER_MS = DEFAULT_TICKS_PER_MS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       cancel,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*DUR_W-1:0] duration,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*DUR_W-1:0] remaining_ms
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    delay_channel #(
      .DUR_W        (DUR_W),
      .TICKS_PER_MS (TICKS_PER_MS)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .start        (start[i]),
      .cancel       (cancel[i]),
      .periodic     (periodic[i]),
      .duration     (duration[i*DUR_W +: DUR_W]),
      .done         (done[i]),
      .busy         (busy[i]),
      .remaining_ms (remaining_ms[i*DUR_W +: DUR_W])
    );
  end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Directed bench for multi_delay_timer with 4 ticks per ms; edge k is counted from
// the start-sampling edge E0 and outputs are sampled 1 time unit after each edge.
module tb_multi_delay_timer;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  start, cancel, periodic;
  logic [31:0] duration;
  logic [3:0]  done, busy;
  logic [31:0] remaining_ms;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multi_delay_timer #(
    .NUM_CH       (4),
    .DUR_W        (8),
    .TICKS_PER_MS (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .cancel       (cancel),
    .periodic     (periodic),
    .duration     (duration),
    .done         (done),
    .busy         (busy),
    .remaining_ms (remaining_ms)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [7:0] rem(input int ch);
    return remaining_ms[ch*8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start on one channel for exactly one edge (that edge is E0).
  task automatic go(input int ch, input logic [7:0] d, input logic per);
    start[ch]           = 1'b1;
    periodic[ch]        = per;
    duration[ch*8 +: 8] = d;
    step();
    start[ch] = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = '0; cancel = '0; periodic = '0; duration = '0;

    for (int i = 0; i < 3; i++) begin
      start    = (i % 2 == 0) ? 4'hF : 4'h5;
      cancel   = ~start;
      periodic = 4'hF;
      duration = 32'h0302_0103;
      step();
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_rem", remaining_ms, 32'(0));
    end
    reset = 1'b1; start = '0; cancel = '0; periodic = '0; duration = '0;
    step();
    chk("idle_busy", 32'(busy), 32'(0));

    go(0, 8'd3, 1'b0);
    chk("os_e0_busy", 32'(busy[0]), 32'(1));
    chk("os_e0_rem", 32'(rem(0)), 32'(3));
    chk("os_e0_done", 32'(done[0]), 32'(0));
    for (int k = 1; k <= 13; k++) begin
      step();
      chk($sformatf("os_done_E%0d", k), 32'(done[0]), 32'(k == 12));
      chk($sformatf("os_busy_E%0d", k), 32'(busy[0]), 32'(k < 12));
      chk($sformatf("os_rem_E%0d", k), 32'(rem(0)), (k < 12) ? 32'(3 - k / 4) : 32'(0));
    end

    go(1, 8'd2, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      step();
      chk($sformatf("per_done_E%0d", k), 32'(done[1]), 32'((k == 8) || (k == 16)));
      chk($sformatf("per_busy_E%0d", k), 32'(busy[1]), 32'(1));
      chk($sformatf("per_rem_E%0d", k), 32'(rem(1)), 32'(2 - (k % 8) / 4));
    end
    cancel[1] = 1'b1;
    step();
    cancel[1] = 1'b0;
    chk("cancel_busy", 32'(busy[1]), 32'(0));
    chk("cancel_rem", 32'(rem(1)), 32'(0));
    chk("cancel_done", 32'(done[1]), 32'(0));
    for (int k = 20; k <= 26; k++) begin
      step();
      chk($sformatf("cancel_done_E%0d", k), 32'(done[1]), 32'(0));
    end

    go(2, 8'd5, 1'b0);
    steps(9);
    go(2, 8'd1, 1'b0);
    chk("retrig_busy", 32'(busy[2]), 32'(1));
    chk("retrig_rem", 32'(rem(2)), 32'(1));
    for (int k = 11; k <= 21; k++) begin
      step();
      chk($sformatf("retrig_done_E%0d", k), 32'(done[2]), 32'(k == 14));
      chk($sformatf("retrig_busy_E%0d", k), 32'(busy[2]), 32'(k < 14));
    end

    go(2, 8'd1, 1'b0);
    steps(3);
    go(2, 8'd2, 1'b0);
    chk("due_supp_done", 32'(done[2]), 32'(0));
    chk("due_supp_rem", 32'(rem(2)), 32'(2));
    for (int k = 5; k <= 13; k++) begin
      step();
      chk($sformatf("due_supp_done_E%0d", k), 32'(done[2]), 32'(k == 12));
    end

    go(2, 8'd0, 1'b0);
    chk("d0_e0_busy", 32'(busy[2]), 32'(1));
    chk("d0_e0_done", 32'(done[2]), 32'(0));
    chk("d0_e0_rem", 32'(rem(2)), 32'(0));
    step();
    chk("d0_e1_done", 32'(done[2]), 32'(1));
    chk("d0_e1_busy", 32'(busy[2]), 32'(0));
    step();
    chk("d0_e2_done", 32'(done[2]), 32'(0));
    go(2, 8'd0, 1'b1);
    step();
    chk("d0p_e1_done", 32'(done[2]), 32'(1));
    chk("d0p_e1_busy", 32'(busy[2]), 32'(0));
    step();
    chk("d0p_e2_done", 32'(done[2]), 32'(0));
    chk("d0p_e2_busy", 32'(busy[2]), 32'(0));

    cancel[3] = 1'b1;
    step();
    cancel[3] = 1'b0;
    chk("cancel_idle_busy", 32'(busy[3]), 32'(0));
    chk("cancel_idle_done", 32'(done[3]), 32'(0));
    cancel[3] = 1'b1;
    go(3, 8'd2, 1'b0);
    cancel[3] = 1'b0;
    chk("sc_busy", 32'(busy[3]), 32'(1));
    chk("sc_rem", 32'(rem(3)), 32'(2));
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("sc_done_E%0d", k), 32'(done[3]), 32'(k == 8));
    end

    start = 4'hF; periodic = 4'h0; duration = 32'h0202_0202;
    step();
    start = '0;
    chk("all_busy_e0", 32'(busy), 32'(4'hF));
    chk("all_rem_e0", remaining_ms, 32'h0202_0202);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("all_done_E%0d", k), 32'(done), (k == 8) ? 32'(4'hF) : 32'(0));
      chk($sformatf("all_busy_E%0d", k), 32'(busy), (k < 8) ? 32'(4'hF) : 32'(0));
    end

    start = 4'hF;
    step();
    start = '0;
    steps(4);
    reset = 1'b0;
    step();
    chk("mrst_done", 32'(done), 32'(0));
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_rem", remaining_ms, 32'(0));
    reset = 1'b1;
    for (int k = 6; k <= 12; k++) begin
      step();
      chk($sformatf("mrst_done_E%0d", k), 32'(done), 32'(0));
      chk($sformatf("mrst_busy_E%0d", k), 32'(busy), 32'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
